// File: rtl/smg_display_arbiter_if.sv
// Request/display bundle between the value sources and the display arbiter.
// The master side drives requests and consumes the display outputs.
interface smg_display_arbiter_if;
    logic [2:0] Req;
    logic [7:0] Req_Data0;
    logic [7:0] Req_Data1;
    logic [7:0] Req_Data2;
    logic [7:0] Number_Data;
    logic [1:0] Owner;
    logic       Busy;
    logic       Ovf_Flag;

    modport master (
        output Req, Req_Data0, Req_Data1, Req_Data2,
        input  Number_Data, Owner, Busy, Ovf_Flag
    );

    modport slave (
        input  Req, Req_Data0, Req_Data1, Req_Data2,
        output Number_Data, Owner, Busy, Ovf_Flag
    );
endinterface

// File: rtl/smg_display_arbiter.sv
// Round-robin arbiter sharing a two-digit display between three value sources,
// holding each granted value for a minimum dwell and saturating it to 0..99.
module smg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter logic [7:0]  IDLE_VALUE  = 8'd0
) (
    input logic                    CLK,
    input logic                    RST_N,
    smg_display_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD} state_t;

    localparam int          CW        = 26;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    state_t          state;
    logic [2:0]      pending;
    logic [7:0]      latch [3];
    logic [CW-1:0]   cnt;
    logic [1:0]      last_owner;
    logic [1:0]      win;
    logic [7:0]      number_q;
    logic [1:0]      owner_q;
    logic            busy_q;
    logic            ovf_q;
    logic [7:0]      req_data [3];

    assign req_data[0] = bus.Req_Data0;
    assign req_data[1] = bus.Req_Data1;
    assign req_data[2] = bus.Req_Data2;

    assign bus.Number_Data = number_q;
    assign bus.Owner       = owner_q;
    assign bus.Busy        = busy_q;
    assign bus.Ovf_Flag    = ovf_q;

    function automatic logic [7:0] sat(input logic [7:0] x);
        return (x > 8'd99) ? 8'd99 : x;
    endfunction

    // First pending requester after 'last', wrapping 2 -> 0; 'last' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [2:0] p, input logic [1:0] last);
        logic [1:0] c;
        logic [1:0] w;
        logic       found;
        c     = last;
        w     = last;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = (c == 2'd2) ? 2'd0 : c + 2'd1;
            if (!found && p[c]) begin
                w     = c;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            pending    <= 3'b000;
            for (int i = 0; i < 3; i++) latch[i] <= 8'd0;
            cnt        <= '0;
            last_owner <= 2'd2;
            win        <= 2'd0;
            number_q   <= IDLE_VALUE;
            owner_q    <= 2'd3;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        win    <= rr_pick(pending, last_owner);
                        state  <= S_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    number_q     <= sat(latch[win]);
                    ovf_q        <= (latch[win] > 8'd99);
                    owner_q      <= win;
                    last_owner   <= win;
                    pending[win] <= 1'b0;
                    cnt          <= '0;
                    state        <= S_HOLD;
                end
                S_HOLD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == HOLD_LAST) begin
                        if (|pending) begin
                            win   <= rr_pick(pending, last_owner);
                            state <= S_LOAD;
                        end else begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // Placed after the LOAD clear so a same-cycle request for the winner re-queues it.
            for (int i = 0; i < 3; i++) begin
                if (bus.Req[i]) begin
                    latch[i] <= req_data[i];
                    if (state == S_HOLD && owner_q == 2'(i)) begin
                        number_q <= sat(req_data[i]);
                        ovf_q    <= (req_data[i] > 8'd99);
                    end else begin
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
